// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard receiver with synchronizers, clock deglitch filter,
// frame FSM with timeout, and break/extended scancode decoding.
module ps2_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyboard,
   output logic       valid,
   output logic       extended,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          filt_q, filt_prev_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          mismatch, flip;
   state_t        state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          par_q, brk_q, ext_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    keyboard_q;
   logic          valid_q, extended_q, frame_err_q;
   logic          sample, bit_w, par_ok, tmo_hit;

   // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   assign mismatch = clk_sync_q[1] != filt_q;
   assign flip     = mismatch && (fcnt_q == FW'(FILTER_LEN - 1));
   assign filt_d   = flip ? ~filt_q : filt_q;
   assign fcnt_d   = (!mismatch || flip) ? '0 : fcnt_q + 1'b1;

   assign sample  = filt_prev_q & ~filt_q;
   assign bit_w   = dat_sync_q[1];
   assign par_ok  = ^{shift_q, par_q};
   assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= '1;
         dat_sync_q  <= '1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         dat_sync_q  <= {dat_sync_q[0], ps2_data};
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         fcnt_q      <= fcnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         tmo_q       <= '0;
         keyboard_q  <= '0;
         valid_q     <= 1'b0;
         extended_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         tmo_q       <= (state_q == IDLE || sample) ? '0 : tmo_q + 1'b1;
         if (sample) begin
            case (state_q)
               IDLE: if (!bit_w) begin
                  state_q   <= DATA;
                  bit_cnt_q <= '0;
               end
               DATA: begin
                  shift_q   <= {bit_w, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_q   <= bit_w;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!bit_w || !par_ok) begin
                     frame_err_q <= 1'b1;
                     brk_q       <= 1'b0;
                     ext_q       <= 1'b0;
                  end else if (shift_q == 8'hF0) begin
                     brk_q <= 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     ext_q <= 1'b1;
                  end else if (brk_q) begin
                     brk_q <= 1'b0;
                     ext_q <= 1'b0;
                  end else begin
                     keyboard_q <= shift_q;
                     extended_q <= ext_q;
                     valid_q    <= 1'b1;
                     ext_q      <= 1'b0;
                  end
               end
            endcase
         end else if (state_q != IDLE && tmo_hit) begin
            // Abandon a stalled frame silently; break/ext flags survive.
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
         end
      end
   end

   assign keyboard  = keyboard_q;
   assign valid     = valid_q;
   assign extended  = extended_q;
   assign frame_err = frame_err_q;
endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted.
REQ-003 clk  input  1  system clock; the block's single clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 keyboard  output  8  last accepted make scancode; held between updates.
REQ-008 valid  output  1  one-cycle strobe: keyboard carries a new make code.
REQ-009 extended  output  1  the make code in keyboard was preceded by 0xE0; updated together with keyboard.
REQ-010 frame_err  output  1  one-cycle strobe on a parity or stop-bit error.

Function
REQ-011 The block SHALL pass ps2_clk and ps2_data through a two-flop synchronizer each.
REQ-012 The block SHALL change the filtered clock level only after FILTER_LEN consecutive synchronized samples differ from the current filtered level; a shorter glitch SHALL NOT change the filtered level.
REQ-013 A sample event SHALL occur on the clk cycle where the filtered clock goes 1->0; the synchronized ps2_data value on that cycle SHALL be the sampled bit.
REQ-014 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-015 IDLE: a sample of 0 (start bit) SHALL go to DATA with the bit counter at 0; a sample of 1 SHALL stay in IDLE.
REQ-016 DATA: each sample SHALL shift into the byte LSB first; after the 8th sample (counter 7) the FSM SHALL go to PARITY.
REQ-017 PARITY: the sample SHALL be stored; the frame parity is good when data bits plus parity bit have an odd count of ones; the FSM SHALL go to STOP.
REQ-018 STOP: a sample of 1 with good parity SHALL complete the byte; otherwise frame_err SHALL pulse for 1 cycle, the byte SHALL be discarded and the break/ext flags cleared; the FSM SHALL return to IDLE in either case.
REQ-019 Timeout: in any non-IDLE state, TIMEOUT_CYCLES clk cycles without a sample event SHALL force IDLE, discard the partial byte and clear the counter; frame_err SHALL NOT pulse; the flags SHALL be kept.
REQ-020 Completed byte 0xF0 SHALL set the break flag with no output.
REQ-021 Completed byte 0xE0 SHALL set the ext flag with no output.
REQ-022 Any other completed byte with the break flag set SHALL clear both flags with no output (key release).
REQ-023 Any other completed byte with the break flag clear SHALL load keyboard with the byte and extended with the ext flag, pulse valid, and clear the ext flag.
REQ-024 valid SHALL assert on the clk cycle immediately after the stop-bit sample event and last exactly 1 cycle; frame_err follows the same timing.
REQ-025 valid and frame_err SHALL never be asserted in the same cycle.
REQ-026 Typematic repeats (the same make code without a break) SHALL each produce a valid pulse.

Reset
REQ-027 rst high SHALL immediately set the FSM to IDLE and clear the counter, shift register, flags and filter counter, with filtered clock = 1 and both synchronizer flops = 1.
REQ-028 During reset, keyboard SHALL be 0x00 and valid, extended and frame_err SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, the first start bit SHALL be decoded normally.

Verification
REQ-030 Frame 0x1D (parity bit 1, stop 1) -> keyboard=0x1D, extended=0, valid high exactly 1 cycle after the stop-bit sample.
REQ-031 Frames F0,1D -> no valid pulse; the next frame 0x1B -> keyboard=0x1B, valid pulses once.
REQ-032 Frames E0,75 -> one valid pulse with keyboard=0x75 and extended=1; the next frame 0x23 -> extended=0.
REQ-033 Frame 0x1C with the parity bit inverted -> one frame_err pulse, no valid, keyboard keeps its previous value.
REQ-034 Start bit plus 3 data bits, then ps2_clk idle for 100000 cycles, then a full 0x23 frame -> no frame_err, then keyboard=0x23 with valid.
REQ-035 ps2_clk low glitches of 5 clk cycles injected between bits of 0x1D, with FILTER_LEN=8 -> glitches ignored and keyboard=0x1D decoded correctly.
